// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the DRAM port arbiter.
//   arb_state_e : arbiter FSM states
//   owner_e     : which requester owns the in-flight access
//   XLEN/CTRL_W : data/address width and rd/wr control width
package mem_arb_pkg;

  localparam int XLEN   = 64;
  localparam int CTRL_W = 3;

  // 64-bit read encoding used for instruction fetches
  localparam logic [CTRL_W-1:0] IF_RD_CTRL_DEF = 3'd5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Access watchdog: counts enabled cycles since the last clear.
//   clk, reset (async, active low)
//   clear_i  : hold count at zero
//   enable_i : count this cycle
//   expire_o : high in the enabled cycle that completes TIMEOUT counted cycles
module mem_arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i)       count_d = '0;
    else if (enable_i) count_d = count_q + CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  // count_q holds the number of cycles already waited, so the current
  // cycle is the TIMEOUT-th one when count_q == TIMEOUT-1
  assign expire_o = enable_i && !clear_i && (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single DRAM port between instruction fetch and the data
// (memory-prepare) requester, returns read data to the issuer and drives
// the pipeline stalls.
//   Fetch side : if_req, if_addr, flush -> if_rdata, if_done, stall_if
//   Data side  : d_rd_ctrl, d_wr_ctrl, d_addr, d_wdata -> d_rdata, d_done, stall_mem
//   DRAM side  : dram_req, dram_addr, dram_din, dram_rd_ctrl, dram_wr_ctrl
//                <- dram_ack, dram_dout
//   timeout_err: sticky flag set when an access is aborted by the watchdog
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int                MAX_D_STREAK = 4,
  parameter int                TIMEOUT      = 255,
  parameter logic [CTRL_W-1:0] IF_RD_CTRL   = IF_RD_CTRL_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [XLEN-1:0]   if_addr,
  input  logic              flush,
  output logic [XLEN-1:0]   if_rdata,
  output logic              if_done,
  input  logic [CTRL_W-1:0] d_rd_ctrl,
  input  logic [CTRL_W-1:0] d_wr_ctrl,
  input  logic [XLEN-1:0]   d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  output logic [XLEN-1:0]   d_rdata,
  output logic              d_done,
  output logic              dram_req,
  output logic [XLEN-1:0]   dram_addr,
  output logic [XLEN-1:0]   dram_din,
  output logic [CTRL_W-1:0] dram_rd_ctrl,
  output logic [CTRL_W-1:0] dram_wr_ctrl,
  input  logic              dram_ack,
  input  logic [XLEN-1:0]   dram_dout,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              timeout_err
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_D_STREAK);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic              kill_q, kill_d;
  logic              req_q, req_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   din_q, din_d;
  logic [CTRL_W-1:0] rd_q, rd_d;
  logic [CTRL_W-1:0] wr_q, wr_d;
  logic [XLEN-1:0]   if_rdata_q, if_rdata_d;
  logic [XLEN-1:0]   d_rdata_q, d_rdata_d;
  logic              terr_q, terr_d;

  logic d_pend, busy, wd_expire;

  assign d_pend = (d_rd_ctrl != '0) || (d_wr_ctrl != '0);
  assign busy   = (state_q == BUSY_I) || (state_q == BUSY_D);

  mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (!busy),
    .enable_i (busy && !dram_ack),
    .expire_o (wd_expire)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    streak_d   = streak_q;
    kill_d     = kill_q;
    req_d      = req_q;
    addr_d     = addr_q;
    din_d      = din_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    terr_d     = terr_q;

    case (state_q)
      IDLE: begin
        // Data has priority unless fetch has already waited out a full streak
        if (d_pend && !(if_req && streak_q == SMAX)) begin
          state_d = BUSY_D;
          owner_d = OWN_D;
          req_d   = 1'b1;
          addr_d  = d_addr;
          din_d   = d_wdata;
          wr_d    = d_wr_ctrl;
          rd_d    = (d_wr_ctrl != '0) ? '0 : d_rd_ctrl;  // write wins
          if (if_req) streak_d = (streak_q == SMAX) ? SMAX : streak_q + SW'(1);
          else        streak_d = '0;
        end else if (if_req && !flush) begin
          state_d  = BUSY_I;
          owner_d  = OWN_I;
          req_d    = 1'b1;
          addr_d   = if_addr;
          din_d    = '0;
          wr_d     = '0;
          rd_d     = IF_RD_CTRL;
          streak_d = '0;
        end else if (!if_req) begin
          streak_d = '0;
        end
      end

      BUSY_I, BUSY_D: begin
        if (dram_ack || wd_expire) begin
          req_d = 1'b0;
          rd_d  = '0;
          wr_d  = '0;
          if (wd_expire) terr_d = 1'b1;
          if (state_q == BUSY_D) begin
            // aborted reads return zero; writes leave d_rdata alone
            if (rd_q != '0) d_rdata_d = dram_ack ? dram_dout : '0;
            state_d = RESP;
          end else if (kill_q || flush) begin
            // flushed fetch: finish on the port silently, no response cycle
            kill_d  = 1'b0;
            state_d = IDLE;
          end else begin
            if_rdata_d = dram_ack ? dram_dout : '0;
            state_d    = RESP;
          end
        end else if (state_q == BUSY_I && flush) begin
          kill_d = 1'b1;
        end
      end

      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      owner_q    <= OWN_I;
      streak_q   <= '0;
      kill_q     <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      streak_q   <= streak_d;
      kill_q     <= kill_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      terr_q     <= terr_d;
    end
  end

  assign if_done      = (state_q == RESP) && (owner_q == OWN_I);
  assign d_done       = (state_q == RESP) && (owner_q == OWN_D);
  assign if_rdata     = if_rdata_q;
  assign d_rdata      = d_rdata_q;
  assign dram_req     = req_q;
  assign dram_addr    = addr_q;
  assign dram_din     = din_q;
  assign dram_rd_ctrl = rd_q;
  assign dram_wr_ctrl = wr_q;
  assign timeout_err  = terr_q;

  // Reset gating keeps the stalls low even while requesters are driving
  assign stall_mem = reset && d_pend && !d_done;
  assign stall_if  = reset && if_req && !if_done && !flush;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [63:0] if_addr;
  logic        flush;
  logic [63:0] if_rdata;
  logic        if_done;
  logic [2:0]  d_rd_ctrl;
  logic [2:0]  d_wr_ctrl;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic [63:0] d_rdata;
  logic        d_done;
  logic        dram_req;
  logic [63:0] dram_addr;
  logic [63:0] dram_din;
  logic [2:0]  dram_rd_ctrl;
  logic [2:0]  dram_wr_ctrl;
  logic        dram_ack;
  logic [63:0] dram_dout;
  logic        stall_if;
  logic        stall_mem;
  logic        timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .flush        (flush),
    .if_rdata     (if_rdata),
    .if_done      (if_done),
    .d_rd_ctrl    (d_rd_ctrl),
    .d_wr_ctrl    (d_wr_ctrl),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_done       (d_done),
    .dram_req     (dram_req),
    .dram_addr    (dram_addr),
    .dram_din     (dram_din),
    .dram_rd_ctrl (dram_rd_ctrl),
    .dram_wr_ctrl (dram_wr_ctrl),
    .dram_ack     (dram_ack),
    .dram_dout    (dram_dout),
    .stall_if     (stall_if),
    .stall_mem    (stall_mem),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] starve_exp [10];

  initial begin
    starve_exp = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd5, 3'd1, 3'd1, 3'd1, 3'd1, 3'd5};

    reset = 1'b0; if_req = 1'b1; if_addr = '0; flush = 1'b0;
    d_rd_ctrl = 3'd5; d_wr_ctrl = '0; d_addr = '0; d_wdata = '0;
    dram_ack = 1'b0; dram_dout = '0;
    #2;
    // ---- reset state (requests driven, stalls must stay low) ----
    chk("rst_dram_req", dram_req, 0);
    chk("rst_stall_if", stall_if, 0);
    chk("rst_stall_mem", stall_mem, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    if_req = 1'b0; d_rd_ctrl = '0;
    #10 reset = 1'b1;

    // ---- single load ----
    cyc(); d_rd_ctrl = 3'd5; d_addr = 64'h8000_0010; #1;              // cycle 0
    chk("ld_c0_req", dram_req, 0);
    chk("ld_c0_stall_mem", stall_mem, 1);
    cyc(); #1;                                                        // cycle 1
    chk("ld_c1_req", dram_req, 1);
    chk("ld_c1_addr", dram_addr, 64'h8000_0010);
    chk("ld_c1_rd", dram_rd_ctrl, 5);
    chk("ld_c1_wr", dram_wr_ctrl, 0);
    cyc(); #1;                                                        // cycle 2
    chk("ld_c2_req", dram_req, 1);
    cyc(); dram_ack = 1'b1; dram_dout = 64'hDEAD_BEEF; #1;            // cycle 3
    chk("ld_c3_req", dram_req, 1);
    chk("ld_c3_stall_mem", stall_mem, 1);
    cyc(); dram_ack = 1'b0; #1;                                       // cycle 4
    chk("ld_c4_req", dram_req, 0);
    chk("ld_c4_d_done", d_done, 1);
    chk("ld_c4_d_rdata", d_rdata, 64'hDEAD_BEEF);
    chk("ld_c4_stall_mem", stall_mem, 0);
    cyc(); d_rd_ctrl = '0; #1;                                        // cycle 5
    chk("ld_c5_d_done", d_done, 0);

    // ---- contention: write wins port first, rd+wr -> write ----
    cyc(); if_req = 1'b1; if_addr = 64'h2000;
    d_wr_ctrl = 3'd3; d_rd_ctrl = 3'd2; d_addr = 64'h100; d_wdata = 64'hCAFE; #1;
    chk("ct_c0_stall_if", stall_if, 1);
    chk("ct_c0_stall_mem", stall_mem, 1);
    cyc(); dram_ack = 1'b1; #1;
    chk("ct_c1_req", dram_req, 1);
    chk("ct_c1_wr", dram_wr_ctrl, 3);
    chk("ct_c1_rd", dram_rd_ctrl, 0);
    chk("ct_c1_din", dram_din, 64'hCAFE);
    chk("ct_c1_addr", dram_addr, 64'h100);
    cyc(); dram_ack = 1'b0; #1;
    chk("ct_c2_d_done", d_done, 1);
    chk("ct_c2_d_rdata_kept", d_rdata, 64'hDEAD_BEEF);
    chk("ct_c2_req", dram_req, 0);
    cyc(); d_wr_ctrl = '0; d_rd_ctrl = '0; #1;
    chk("ct_c3_req", dram_req, 0);
    cyc(); dram_ack = 1'b1; dram_dout = 64'h1111_2222_3333_4444; #1;
    chk("ct_c4_req", dram_req, 1);
    chk("ct_c4_addr", dram_addr, 64'h2000);
    chk("ct_c4_rd", dram_rd_ctrl, 5);
    chk("ct_c4_wr", dram_wr_ctrl, 0);
    chk("ct_c4_din", dram_din, 0);
    cyc(); dram_ack = 1'b0; #1;
    chk("ct_c5_if_done", if_done, 1);
    chk("ct_c5_if_rdata", if_rdata, 64'h1111_2222_3333_4444);
    chk("ct_c5_stall_if", stall_if, 0);

    // ---- starvation: ack held high, both requesters always pending ----
    cyc(); if_req = 1'b1; if_addr = 64'h3000; d_rd_ctrl = 3'd1; d_addr = 64'h40;
    dram_ack = 1'b1; dram_dout = 64'h5555;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin
        cyc();
        cyc();
      end
      cyc(); #1;
      chk($sformatf("sv_grant%0d_req", k), dram_req, 1);
      chk($sformatf("sv_grant%0d_rd", k), dram_rd_ctrl, starve_exp[k]);
    end
    cyc(); if_req = 1'b0; d_rd_ctrl = '0; dram_ack = 1'b0; #1;
    chk("sv_resp_if_done", if_done, 1);
    cyc(); #1;
    chk("sv_idle_req", dram_req, 0);

    // ---- flush while fetch in flight ----
    cyc(); if_req = 1'b1; if_addr = 64'h3000; #1;
    cyc(); flush = 1'b1; #1;
    chk("fl_c1_req", dram_req, 1);
    chk("fl_c1_stall_if", stall_if, 0);
    cyc(); flush = 1'b0; if_req = 1'b0; dram_ack = 1'b1; dram_dout = 64'h1234; #1;
    chk("fl_c2_req", dram_req, 1);
    cyc(); dram_ack = 1'b0; d_rd_ctrl = 3'd5; d_addr = 64'h88; #1;
    chk("fl_c3_req", dram_req, 0);
    chk("fl_c3_if_done", if_done, 0);
    chk("fl_c3_if_rdata", if_rdata, 64'h5555);

    // ---- timeout: the load granted straight from IDLE is never acked ----
    cyc(); #1;
    chk("to_busy_req", dram_req, 1);
    for (int i = 0; i < 254; i++) cyc();
    #1;
    chk("to_last_busy_req", dram_req, 1);
    chk("to_last_busy_terr", timeout_err, 0);
    cyc(); #1;
    chk("to_resp_req", dram_req, 0);
    chk("to_resp_terr", timeout_err, 1);
    chk("to_resp_d_done", d_done, 1);
    chk("to_resp_d_rdata", d_rdata, 0);
    cyc(); d_rd_ctrl = '0; #1;
    chk("to_after_d_done", d_done, 0);
    chk("to_after_terr", timeout_err, 1);

    // ---- reset in the middle of a data access ----
    cyc(); d_wr_ctrl = 3'd1; d_addr = 64'h77; d_wdata = 64'h99; #1;
    cyc(); #1;
    chk("rm_busy_req", dram_req, 1);
    reset = 1'b0; #1;
    chk("rm_async_req", dram_req, 0);
    chk("rm_async_addr", dram_addr, 0);
    chk("rm_async_terr", timeout_err, 0);
    chk("rm_async_stall_mem", stall_mem, 0);
    chk("rm_async_if_rdata", if_rdata, 0);
    #3 reset = 1'b1;
    cyc(); dram_ack = 1'b1; #1;
    chk("rm_regrant_req", dram_req, 1);
    chk("rm_regrant_wr", dram_wr_ctrl, 1);
    chk("rm_regrant_din", dram_din, 64'h99);
    cyc(); dram_ack = 1'b0; #1;
    chk("rm_d_done", d_done, 1);
    chk("rm_d_rdata", d_rdata, 0);
    cyc(); d_wr_ctrl = '0; #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single DRAM port between the instruction-fetch requester and the memory-prepare data requester.
- Sequences each access as a req/ack transaction and returns read data to the requester that issued it.
- Generates the stall signals that freeze IF and the memory stages while their access is outstanding.
- Sits between the pipeline front end, the memory-prepare stage and the DRAM controller.

Parameters:
- MAX_D_STREAK, 4: consecutive data grants allowed while a fetch is waiting; the next grant after that goes to fetch.
- TIMEOUT, 255: cycles to wait for dram_ack before aborting the access.
- IF_RD_CTRL, 3'd5: rd_ctrl encoding used for fetches (64-bit read, per the shared defines).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request (level, held until if_done)
- if_addr  in  64  fetch address
- flush  in  1  branch flush; cancels the pending or in-flight fetch
- if_rdata  out  64  fetched data
- if_done  out  1  one-cycle completion pulse for fetch
- d_rd_ctrl  in  3  data read control; nonzero means request (held until d_done)
- d_wr_ctrl  in  3  data write control; nonzero means request
- d_addr  in  64  data address
- d_wdata  in  64  store data
- d_rdata  out  64  load data
- d_done  out  1  one-cycle completion pulse for data
- dram_req  out  1  transaction valid
- dram_addr  out  64  DRAM address
- dram_din  out  64  DRAM write data
- dram_rd_ctrl  out  3  DRAM read control
- dram_wr_ctrl  out  3  DRAM write control
- dram_ack  in  1  transaction accepted/complete
- dram_dout  in  64  DRAM read data, valid when dram_ack is high
- stall_if  out  1  freeze fetch
- stall_mem  out  1  freeze memory stages
- timeout_err  out  1  sticky abort flag

Behaviour:
- Reset (reset low, async): state IDLE; streak and watchdog counters 0; kill flag 0. All outputs 0, including rdata registers, timeout_err and both stalls.
- States: IDLE, BUSY_I, BUSY_D, RESP.
- d_pend = (d_rd_ctrl != 0) or (d_wr_ctrl != 0).
- IDLE arbitration:
  - d_pend and not (if_req and streak == MAX_D_STREAK): grant data.
  - Otherwise, if_req and not flush: grant fetch.
  - Otherwise stay in IDLE.
- Grant timing: grant decided in cycle N. dram_req and dram_* registered at edge N+1 and held stable until ack.
- Data grant outputs: dram_addr = d_addr, dram_din = d_wdata, dram_wr_ctrl = d_wr_ctrl. If both rd and wr are nonzero, the write wins and dram_rd_ctrl = 0.
- Fetch grant outputs: dram_addr = if_addr, dram_rd_ctrl = IF_RD_CTRL, dram_wr_ctrl = 0, dram_din = 0.
- Streak counter:
  - Data grant with if_req high: streak + 1, saturating at MAX_D_STREAK.
  - Fetch grant, or if_req low in IDLE: streak cleared.
- BUSY_x: dram_req stays 1. On the edge where dram_ack = 1:
  - dram_req and all dram_* ctrl go to 0.
  - On a read, capture dram_dout into the matching rdata register; d_rdata is unchanged on writes.
  - Go to RESP.
- RESP: lasts exactly one cycle. Pulse the matching done signal, make no grant, return to IDLE. Minimum access = 3 cycles (grant, ack, resp), with one bubble between back-to-back accesses.
- Flush:
  - flush in IDLE blocks a fetch grant that cycle.
  - flush during BUSY_I sets kill. The transaction still completes on the port; on ack, if_rdata is not updated, if_done is not pulsed, and the FSM goes straight to IDLE. kill clears on that exit.
- Watchdog:
  - Counts cycles in BUSY_x without ack.
  - When it reaches TIMEOUT: drop dram_req, set timeout_err (sticky until reset), enter RESP.
  - The done pulse still fires so the pipeline is released; read data in that case is 0.
- Stalls (combinational):
  - stall_mem = d_pend and not d_done.
  - stall_if = if_req and not if_done and not flush.
  - Both forced to 0 while reset is low.
- dram_ack outside BUSY_x is ignored.
- Requesters must deassert or change their request in the cycle after done. The RESP bubble guarantees no double grant.

Decomposition:
- Package mem_arb_pkg:
  - state enum typedef (IDLE, BUSY_I, BUSY_D, RESP)
  - owner enum (OWN_I, OWN_D)
  - IF_RD_CTRL default constant
  - width constants
- Sub-module mem_arb_watchdog: counter with clear, enable and parameter TIMEOUT; expire output.

Test Plan:
- Single load: d_rd_ctrl = 5, d_addr = 0x8000_0010 at cycle 0, ack at cycle 3 with dout = 0xDEAD_BEEF → dram_req high cycles 1-3, d_done pulse at cycle 4, d_rdata = 0xDEAD_BEEF, stall_mem high cycles 0-3.
- Contention: if_req and d_wr_ctrl = 3 both asserted in the same cycle, ack after 1 cycle → data granted first with dram_wr_ctrl = 3 and dram_rd_ctrl = 0; fetch granted in the IDLE after RESP.
- Starvation: continuous data requests plus if_req held high → exactly MAX_D_STREAK = 4 data grants, then 1 fetch grant, then the streak restarts.
- Flush in flight: fetch granted, flush pulsed during BUSY_I, ack with dout = 0x1234 → no if_done, if_rdata unchanged, FSM back to IDLE.
- Timeout: data read, dram_ack never asserted → after 255 BUSY cycles dram_req = 0, timeout_err = 1 (held), d_done pulses, d_rdata = 0.
- Reset mid-access: reset low during BUSY_D → dram_req = 0 immediately (asynchronously), all outputs 0; after release the next request is granted normally.
